// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetches the word at pc_in over a req/ack memory port into a one-entry buffer,
// stalling the core until it hits and faulting on misaligned PCs or memory timeouts.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_INST = 32'h0000_0013,
  parameter int          TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic [31:0] inst_out,
  output logic        inst_valid,
  output logic        cpu_stall,
  output logic        fetch_fault,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, WAIT, FAULT} state_t;
  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);
  state_t      state, state_n;
  logic [31:0] buf_pc, buf_inst, req_pc, fault_pc;
  logic        buf_valid, discard, hit, start, fill, expire;
  logic [7:0]  cnt;
  assign hit         = buf_valid && buf_pc == pc_in;
  assign fetch_fault = state == FAULT;
  assign inst_valid  = hit && !fetch_fault;
  assign cpu_stall   = ~inst_valid;
  assign inst_out    = inst_valid ? buf_inst : RESET_INST;
  always_comb begin
    state_n = state;
    start   = 1'b0;
    fill    = 1'b0;
    expire  = 1'b0;
    case (state)
      IDLE: if (!hit) begin
        start   = pc_in[1:0] == 2'b00;
        state_n = start ? WAIT : FAULT;
      end
      WAIT: if (imem_ack) begin
        fill    = !discard && !flush;
        state_n = IDLE;
      end else if (cnt == T_LAST) begin
        expire  = 1'b1;
        state_n = FAULT;
      end
      FAULT:   state_n = (flush || pc_in != fault_pc) ? IDLE : FAULT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      buf_pc      <= '0;
      buf_inst    <= '0;
      buf_valid   <= 1'b0;
      req_pc      <= '0;
      fault_pc    <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      discard     <= 1'b0;
      cnt         <= '0;
      fetch_count <= '0;
    end else begin
      state     <= state_n;
      buf_valid <= flush ? 1'b0 : (fill ? 1'b1 : buf_valid);
      if (start) begin
        imem_req  <= 1'b1;
        imem_addr <= {pc_in[31:2], 2'b00};
        req_pc    <= pc_in;
        cnt       <= '0;
        discard   <= 1'b0;
      end
      if (state == WAIT) begin
        if (imem_ack || expire) imem_req <= 1'b0;
        else cnt <= cnt + 8'd1;
        discard <= !imem_ack && (discard || flush);
      end
      // A timed-out fetch is blamed on the PC it was issued for, not whatever pc_in has become
      if (state == IDLE && state_n == FAULT) fault_pc <= pc_in;
      if (expire) fault_pc <= req_pc;
      if (fill) begin
        buf_pc      <= req_pc;
        buf_inst    <= imem_rdata;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed stimulus pushes expected requests and fills into queues;
// a negedge monitor pops and compares on every imem_req and inst_valid rising edge.
module tb_inst_fetch_unit;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] cnt;
  } fill_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0;
  logic        flush = 1'b0;
  logic [31:0] inst_out;
  logic        inst_valid, cpu_stall, fetch_fault, imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] fetch_count;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] aq[$];
  fill_t       fq[$];
  logic        req_q = 1'b0;
  logic        valid_q = 1'b0;

  inst_fetch_unit #(.RESET_INST(32'h0000_0013), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .flush(flush),
    .inst_out(inst_out), .inst_valid(inst_valid), .cpu_stall(cpu_stall),
    .fetch_fault(fetch_fault), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input logic [31:0] pc, input logic a = 1'b0,
                      input logic [31:0] d = '0, input logic f = 1'b0);
    @(posedge clk);
    #1;
    pc_in = pc;
    imem_ack = a;
    imem_rdata = d;
    flush = f;
    @(negedge clk);
  endtask

  task automatic release_rst(input logic [31:0] pc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pc_in = pc;
    imem_ack = 1'b0;
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_fill(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] cnt);
    fill_t e;
    e.pc = pc;
    e.inst = inst;
    e.cnt = cnt;
    fq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (imem_req && !req_q) begin
      if (aq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
      end else check("req_addr", imem_addr, aq.pop_front());
    end
    if (inst_valid && !valid_q) begin
      if (fq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: got pc %h inst %h expected no fill", pc_in, inst_out);
      end else begin
        fill_t e;
        e = fq.pop_front();
        check("fill_pc", pc_in, e.pc);
        check("fill_inst", inst_out, e.inst);
        check("fill_count", fetch_count, e.cnt);
      end
    end
    req_q = imem_req;
    valid_q = inst_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish within budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_inst_out", inst_out, 32'h0000_0013);
    check("rst_flags", 32'({inst_valid, cpu_stall, fetch_fault, imem_req}), 32'b0100);
    check("rst_count", fetch_count, 0);
    // first fetch of 0x0, ack in the third request cycle
    aq.push_back(32'h0);
    release_rst(32'h0);
    check("miss_c0_req", 32'(imem_req), 0);
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) push_fill(32'h0, 32'h0050_0093, 1);
      tick(32'h0, i == 3, 32'h0050_0093);
      check("miss_req_high", 32'({imem_req, inst_valid}), 32'b10);
    end
    tick(32'h0);
    check("fill_c4", 32'({imem_req, inst_valid, cpu_stall}), 32'b010);
    for (int i = 0; i < 10; i++) begin
      tick(32'h0);
      check("hold_req_stall", 32'({imem_req, cpu_stall}), 0);
    end
    // pc moves to 0x4 while 0x0 is outstanding
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_count", fetch_count, 0);
    aq.push_back(32'h0);
    release_rst(32'h0);
    tick(32'h0);
    tick(32'h4);
    tick(32'h4, 1'b1, 32'h0010_0093);
    tick(32'h4);
    check("stale_fill_miss", 32'({inst_valid, imem_req}), 0);
    check("stale_fill_count", fetch_count, 1);
    aq.push_back(32'h4);
    tick(32'h4);
    push_fill(32'h4, 32'h0020_0113, 2);
    tick(32'h4, 1'b1, 32'h0020_0113);
    check("refetch_ack_stall", 32'(cpu_stall), 1);
    tick(32'h4);
    // misaligned pc faults without a request, then a new pc recovers
    tick(32'h6);
    check("mis_c0", 32'({fetch_fault, imem_req}), 0);
    for (int i = 0; i < 2; i++) begin
      tick(32'h6);
      check("mis_fault", 32'({fetch_fault, imem_req, inst_valid, cpu_stall}), 32'b1001);
    end
    tick(32'h8);
    check("mis_exit_c0", 32'(fetch_fault), 1);
    tick(32'h8);
    check("mis_exit_c1", 32'({fetch_fault, imem_req}), 0);
    aq.push_back(32'h8);
    tick(32'h8);
    push_fill(32'h8, 32'h0030_0193, 3);
    tick(32'h8, 1'b1, 32'h0030_0193);
    tick(32'h8);
    // timeout: four request cycles, fault, buffer still holds 0x8
    aq.push_back(32'hC);
    tick(32'hC);
    for (int i = 0; i < 4; i++) begin
      tick(32'hC);
      check("to_req_high", 32'({imem_req, fetch_fault}), 32'b10);
    end
    tick(32'hC);
    check("to_fault", 32'({imem_req, fetch_fault, inst_valid}), 32'b010);
    tick(32'h8);
    push_fill(32'h8, 32'h0030_0193, 3);
    tick(32'h8);
    check("to_buf_kept_req", 32'(imem_req), 0);
    // second timeout, left through flush
    aq.push_back(32'hC);
    tick(32'hC);
    repeat (4) tick(32'hC);
    tick(32'hC);
    check("to2_fault", 32'(fetch_fault), 1);
    tick(32'hC, 1'b0, '0, 1'b1);
    tick(32'hC);
    check("flush_exit", 32'({fetch_fault, imem_req}), 0);
    aq.push_back(32'hC);
    tick(32'hC);
    push_fill(32'hC, 32'h0040_0213, 4);
    tick(32'hC, 1'b1, 32'h0040_0213);
    tick(32'hC);
    // flush during WAIT discards the response
    aq.push_back(32'h10);
    tick(32'h10);
    tick(32'h10, 1'b0, '0, 1'b1);
    tick(32'h10, 1'b1, 32'hDEAD_BEEF);
    tick(32'h10);
    check("discard_count", fetch_count, 4);
    check("discard_valid", 32'(inst_valid), 0);
    aq.push_back(32'h10);
    tick(32'h10);
    push_fill(32'h10, 32'h0050_0293, 5);
    tick(32'h10, 1'b1, 32'h0050_0293);
    tick(32'h10);
    // flush coincident with ack
    aq.push_back(32'h14);
    tick(32'h14);
    tick(32'h14);
    tick(32'h14, 1'b1, 32'hDEAD_BEEF, 1'b1);
    tick(32'h14);
    check("coinc_count", fetch_count, 5);
    aq.push_back(32'h14);
    tick(32'h14);
    push_fill(32'h14, 32'h0060_0313, 6);
    tick(32'h14, 1'b1, 32'h0060_0313);
    tick(32'h14);
    // reset in the middle of WAIT
    aq.push_back(32'h18);
    tick(32'h18);
    tick(32'h18);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 0);
    check("midrst_inst", inst_out, 32'h0000_0013);
    @(negedge clk);
    tick(32'h18, 1'b1, 32'hDEAD_BEEF);
    aq.push_back(32'h18);
    @(posedge clk);
    #1;
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("late_ack_count", fetch_count, 0);
    tick(32'h18);
    push_fill(32'h18, 32'h0070_0393, 1);
    tick(32'h18, 1'b1, 32'h0070_0393);
    tick(32'h18);
    tick(32'h18);
    check("addr_q_empty", aq.size(), 0);
    check("fill_q_empty", fq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
